lab2_proc_alu_arbiter: RTL and testbench

Shares one combinational integer ALU (the team's existing lab2_proc ALU) between two requesters, for example the X-stage and a branch/address helper unit. Each requester uses val/rdy handshakes on separate request and response interfaces. A round-robin grant picks the winner each cycle. A single-entry registered response buffer returns the ALU result and comparison flags one cycle after acceptance. The block sits beside the X stage inside the processor datapath.

---
 rtl/lab2_proc_alu_arb_pkg.sv | 38 +++
 rtl/lab2_proc_alu.sv | 50 +++++
 rtl/lab2_proc_rr_arb2.sv | 50 +++++
 rtl/lab2_proc_alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_lab2_proc_alu_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lab2_proc_alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - ALU function codes, using the same encoding as the shared lab2_proc ALU
//   - requester id type
//   - comparison-flag struct; each module pairs it with its own result width
//   - helper that returns the other requester id
package lab2_proc_alu_arb_pkg;

  localparam logic [3:0] ALU_FN_ADD    = 4'd0;
  localparam logic [3:0] ALU_FN_SUB    = 4'd1;
  localparam logic [3:0] ALU_FN_SLL    = 4'd2;
  localparam logic [3:0] ALU_FN_OR     = 4'd3;
  localparam logic [3:0] ALU_FN_SLT    = 4'd4;
  localparam logic [3:0] ALU_FN_SLTU   = 4'd5;
  localparam logic [3:0] ALU_FN_AND    = 4'd6;
  localparam logic [3:0] ALU_FN_XOR    = 4'd7;
  localparam logic [3:0] ALU_FN_NOR    = 4'd8;
  localparam logic [3:0] ALU_FN_SRL    = 4'd9;
  localparam logic [3:0] ALU_FN_SRA    = 4'd10;
  localparam logic [3:0] ALU_FN_CP_OP0 = 4'd11;
  localparam logic [3:0] ALU_FN_CP_OP1 = 4'd12;
  localparam logic [3:0] ALU_FN_ADDZ   = 4'd13;

  typedef enum logic {
    REQ_ID_0 = 1'b0,
    REQ_ID_1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } alu_flags_t;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
  endfunction

endpackage

// File: rtl/lab2_proc_alu.sv
// Shared combinational integer ALU (the lab2_proc ALU, instantiated as is).
// Ports: fn (function code), in0/in1 (operands), out (result),
//        ops_eq/ops_lt/ops_ltu (comparison flags, computed for any fn).
// Function codes without an operation defined for them produce out = 0.
module lab2_proc_alu
  import lab2_proc_alu_arb_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic [3:0]         fn,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out,
  output logic               ops_eq,
  output logic               ops_lt,
  output logic               ops_ltu
);

  localparam int SHW = $clog2(p_nbits);

  logic [SHW-1:0] shamt_s;
  assign shamt_s = in1[SHW-1:0];

  // Result select and operand comparisons
  always_comb begin
    ops_eq  = (in0 == in1);
    ops_lt  = ($signed(in0) < $signed(in1));
    ops_ltu = (in0 < in1);
    out     = '0;
    case (fn)
      ALU_FN_ADD:    out = in0 + in1;
      ALU_FN_SUB:    out = in0 - in1;
      ALU_FN_SLL:    out = in0 << shamt_s;
      ALU_FN_OR:     out = in0 | in1;
      ALU_FN_SLT:    out = {{(p_nbits-1){1'b0}}, ops_lt};
      ALU_FN_SLTU:   out = {{(p_nbits-1){1'b0}}, ops_ltu};
      ALU_FN_AND:    out = in0 & in1;
      ALU_FN_XOR:    out = in0 ^ in1;
      ALU_FN_NOR:    out = ~(in0 | in1);
      ALU_FN_SRL:    out = in0 >> shamt_s;
      ALU_FN_SRA:    out = $signed(in0) >>> shamt_s;
      ALU_FN_CP_OP0: out = in0;
      ALU_FN_CP_OP1: out = in1;
      // Jump-target add: clear bit 0 of the sum
      ALU_FN_ADDZ:   out = (in0 + in1) & ~{{(p_nbits-1){1'b0}}, 1'b1};
      default:       out = '0;
    endcase
  end

endmodule

// File: rtl/lab2_proc_rr_arb2.sv
// Two-input round-robin arbiter with a registered priority bit.
// Ports: clk, reset (async active-low), en (grant allowed this cycle),
//        val[1:0] (request valids), gnt[1:0] (one-hot grant, already gated
//        by en), grant_id (winner id when any request is valid).
// The priority bit moves to the loser only on cycles where a grant is issued.
module lab2_proc_rr_arb2
  import lab2_proc_alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] val,
  output logic [1:0] gnt,
  output req_id_e    grant_id
);

  req_id_e prio_r;
  logic    any_s;

  // Pick the winner: a lone valid wins, a tie goes to the priority holder
  always_comb begin
    grant_id = prio_r;
    if (val[0] && val[1]) begin
      grant_id = prio_r;
    end else if (val[1]) begin
      grant_id = REQ_ID_1;
    end else begin
      grant_id = REQ_ID_0;
    end
    any_s = en & (val[0] | val[1]);
    gnt   = 2'b00;
    if (any_s) begin
      gnt = (grant_id == REQ_ID_1) ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

  // Priority register: the winner drops to lowest priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_r <= REQ_ID_0;
    end else if (any_s) begin
      prio_r <= other_req(grant_id);
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/lab2_proc_alu_arbiter.sv
// Shares one combinational ALU between two val/rdy requesters.
// A round-robin arbiter picks the winner, the ALU result and flags are
// captured in a single-entry response buffer and returned one cycle later
// on the owner's response interface.
// Ports:
//   clk, reset (async active-low)
//   req{0,1}_val/rdy/fn/in0/in1 : request interfaces
//   resp{0,1}_val/rdy/out/eq/lt/ltu : response interfaces (driven from buffer)
//   grant{0,1}_cnt : saturating grant counters, present only when
//                    LAB2_PROC_ALU_ARB_STATS_EN is defined
module lab2_proc_alu_arbiter
  import lab2_proc_alu_arb_pkg::*;
#(
  parameter int p_nbits     = 32,
  parameter int p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [3:0]             req0_fn,
  input  logic [p_nbits-1:0]     req0_in0,
  input  logic [p_nbits-1:0]     req0_in1,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [3:0]             req1_fn,
  input  logic [p_nbits-1:0]     req1_in0,
  input  logic [p_nbits-1:0]     req1_in1,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [p_nbits-1:0]     resp0_out,
  output logic                   resp0_eq,
  output logic                   resp0_lt,
  output logic                   resp0_ltu,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [p_nbits-1:0]     resp1_out,
  output logic                   resp1_eq,
  output logic                   resp1_lt,
  output logic                   resp1_ltu
`ifdef LAB2_PROC_ALU_ARB_STATS_EN
  ,
  output logic [p_cnt_nbits-1:0] grant0_cnt,
  output logic [p_cnt_nbits-1:0] grant1_cnt
`endif
);

  typedef struct packed {
    logic [p_nbits-1:0] out;
    alu_flags_t         flags;
  } resp_t;

  logic               full_r;
  req_id_e            owner_r;
  resp_t              resp_r;

  logic               resp_fire_s;
  logic               can_accept_s;
  logic [1:0]         gnt_s;
  req_id_e            grant_id_s;
  logic               req_fire_s;
  logic [3:0]         alu_fn_s;
  logic [p_nbits-1:0] alu_in0_s;
  logic [p_nbits-1:0] alu_in1_s;
  logic [p_nbits-1:0] alu_out_s;
  alu_flags_t         alu_flags_s;

  assign resp_fire_s  = full_r & ((owner_r == REQ_ID_1) ? resp1_rdy : resp0_rdy);
  assign can_accept_s = ~full_r | resp_fire_s;

  // Gating with reset keeps both rdy outputs low while reset is held
  lab2_proc_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (can_accept_s & reset),
    .val      ({req1_val, req0_val}),
    .gnt      (gnt_s),
    .grant_id (grant_id_s)
  );

  assign req0_rdy   = gnt_s[0];
  assign req1_rdy   = gnt_s[1];
  assign req_fire_s = gnt_s[0] | gnt_s[1];

  // Steer the winner's operation into the shared ALU
  always_comb begin
    if (grant_id_s == REQ_ID_1) begin
      alu_fn_s  = req1_fn;
      alu_in0_s = req1_in0;
      alu_in1_s = req1_in1;
    end else begin
      alu_fn_s  = req0_fn;
      alu_in0_s = req0_in0;
      alu_in1_s = req0_in1;
    end
  end

  lab2_proc_alu #(.p_nbits(p_nbits)) u_alu (
    .fn      (alu_fn_s),
    .in0     (alu_in0_s),
    .in1     (alu_in1_s),
    .out     (alu_out_s),
    .ops_eq  (alu_flags_s.eq),
    .ops_lt  (alu_flags_s.lt),
    .ops_ltu (alu_flags_s.ltu)
  );

  // Response buffer: a new fire overwrites, a lone response fire drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r  <= 1'b0;
      owner_r <= REQ_ID_0;
      resp_r  <= '0;
    end else if (req_fire_s) begin
      full_r  <= 1'b1;
      owner_r <= grant_id_s;
      resp_r  <= {alu_out_s, alu_flags_s};
    end else if (resp_fire_s) begin
      full_r  <= 1'b0;
    end
  end

  assign resp0_val = full_r & (owner_r == REQ_ID_0);
  assign resp1_val = full_r & (owner_r == REQ_ID_1);
  assign resp0_out = resp_r.out;
  assign resp0_eq  = resp_r.flags.eq;
  assign resp0_lt  = resp_r.flags.lt;
  assign resp0_ltu = resp_r.flags.ltu;
  assign resp1_out = resp_r.out;
  assign resp1_eq  = resp_r.flags.eq;
  assign resp1_lt  = resp_r.flags.lt;
  assign resp1_ltu = resp_r.flags.ltu;

`ifdef LAB2_PROC_ALU_ARB_STATS_EN
  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (gnt_s[0] && (grant0_cnt != '1)) grant0_cnt <= grant0_cnt + 1'b1;
      else                                grant0_cnt <= grant0_cnt;
      if (gnt_s[1] && (grant1_cnt != '1)) grant1_cnt <= grant1_cnt + 1'b1;
      else                                grant1_cnt <= grant1_cnt;
    end
  end
`else
  logic [p_cnt_nbits-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
`endif

endmodule

// File: tb/tb_lab2_proc_alu_arbiter.sv
// Directed self-checking bench for lab2_proc_alu_arbiter.
module tb_lab2_proc_alu_arbiter;

`ifdef LAB2_PROC_ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req0_val, req0_rdy, req1_val, req1_rdy;
  logic [3:0] req0_fn, req1_fn;
  logic [31:0] req0_in0, req0_in1, req1_in0, req1_in1;
  logic resp0_val, resp0_rdy, resp0_eq, resp0_lt, resp0_ltu;
  logic resp1_val, resp1_rdy, resp1_eq, resp1_lt, resp1_ltu;
  logic [31:0] resp0_out, resp1_out;
`ifdef LAB2_PROC_ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_cnt, grant1_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  lab2_proc_alu_arbiter #(.p_nbits(32), .p_cnt_nbits(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_fn(req0_fn),
    .req0_in0(req0_in0), .req0_in1(req0_in1),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_fn(req1_fn),
    .req1_in0(req1_in0), .req1_in1(req1_in1),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_out(resp0_out),
    .resp0_eq(resp0_eq), .resp0_lt(resp0_lt), .resp0_ltu(resp0_ltu),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_out(resp1_out),
    .resp1_eq(resp1_eq), .resp1_lt(resp1_lt), .resp1_ltu(resp1_ltu)
`ifdef LAB2_PROC_ALU_ARB_STATS_EN
    , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic v, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    req0_val = v; req0_fn = fn; req0_in0 = a; req0_in1 = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    req1_val = v; req1_fn = fn; req1_in0 = a; req1_in1 = b;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_req0(1'b1, 4'd0, 32'd3, 32'd4);
    set_req1(1'b1, 4'd0, 32'd0, 32'd0);
    resp0_rdy = 1'b0;
    resp1_rdy = 1'b0;

    // Reset state: no valids, no readies even with requests pending
    #3;
    chk("rst_req0_rdy", req0_rdy, 1'b0);
    chk("rst_req1_rdy", req1_rdy, 1'b0);
    chk("rst_resp0_val", resp0_val, 1'b0);
    chk("rst_resp1_val", resp1_val, 1'b0);
    @(posedge clk); #1;
    chk("rst_resp0_val_clk", resp0_val, 1'b0);

    // Fill the buffer, then reset mid-operation
    @(negedge clk);
    reset = 1'b1;
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    #1 chk("fill_req0_rdy", req0_rdy, 1'b1);
    @(posedge clk); #1;
    chk("fill_resp0_val", resp0_val, 1'b1);
    chk("fill_resp0_out", resp0_out, 32'd7);
    reset = 1'b0;
    #1;
    chk("async_rst_resp0_val", resp0_val, 1'b0);
    chk("async_rst_resp1_val", resp1_val, 1'b0);
    chk("async_rst_req0_rdy", req0_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    resp0_rdy = 1'b1;
    #1 chk("post_rst_req0_rdy", req0_rdy, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_resp0_val", resp0_val, 1'b1);
    chk("post_rst_resp0_out", resp0_out, 32'd7);

    // Streaming on requester 0
    @(negedge clk);
    set_req0(1'b1, 4'd0, 32'd5, 32'd6);
    #1 chk("stream0_req0_rdy", req0_rdy, 1'b1);
    @(posedge clk); #1;
    chk("stream0_val", resp0_val, 1'b1);
    chk("stream0_out", resp0_out, 32'd11);
    @(negedge clk);
    set_req0(1'b1, 4'd0, 32'd1, 32'd1);
    #1 chk("stream1_req0_rdy", req0_rdy, 1'b1);
    @(posedge clk); #1;
    chk("stream1_val", resp0_val, 1'b1);
    chk("stream1_out", resp0_out, 32'd2);
    @(negedge clk);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("stream_drain_val", resp0_val, 1'b0);

    // Contention: grants alternate 0,1,0,1 starting from requester 0
    pulse_reset();
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_req0(1'b1, 4'd0, 32'd1, 32'd1);
      set_req1(1'b1, 4'd12, 32'd0, 32'd9);
      #1;
      chk($sformatf("rr%0d_req0_rdy", k), req0_rdy, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d_req1_rdy", k), req1_rdy, (k % 2 == 0) ? 1'b0 : 1'b1);
      @(posedge clk); #1;
      chk($sformatf("rr%0d_resp0_val", k), resp0_val, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d_resp1_val", k), resp1_val, (k % 2 == 0) ? 1'b0 : 1'b1);
      chk($sformatf("rr%0d_out", k), resp0_out, (k % 2 == 0) ? 32'd2 : 32'd9);
    end

    // Backpressure on requester 1
    @(negedge clk);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b1, 4'd12, 32'd0, 32'h55);
    #1 chk("bp_req1_rdy", req1_rdy, 1'b1);
    @(posedge clk); #1;
    chk("bp_resp1_val", resp1_val, 1'b1);
    chk("bp_resp1_out", resp1_out, 32'h55);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      resp1_rdy = 1'b0;
      set_req1(1'b0, 4'd0, 32'd0, 32'd0);
      set_req0(1'b1, 4'd0, 32'd10, 32'd20);
      #1;
      chk($sformatf("stall%0d_req0_rdy", k), req0_rdy, 1'b0);
      chk($sformatf("stall%0d_req1_rdy", k), req1_rdy, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_resp1_val", k), resp1_val, 1'b1);
      chk($sformatf("stall%0d_resp1_out", k), resp1_out, 32'h55);
    end
    @(negedge clk);
    resp1_rdy = 1'b1;
    #1 chk("unstall_req0_rdy", req0_rdy, 1'b1);
    @(posedge clk); #1;
    chk("unstall_resp0_val", resp0_val, 1'b1);
    chk("unstall_resp1_val", resp1_val, 1'b0);
    chk("unstall_resp0_out", resp0_out, 32'd30);

    // Comparison flags
    @(negedge clk);
    set_req0(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    chk("flag1_out", resp0_out, 32'd0);
    chk("flag1_eq", resp0_eq, 1'b0);
    chk("flag1_lt", resp0_lt, 1'b1);
    chk("flag1_ltu", resp0_ltu, 1'b0);
    @(negedge clk);
    set_req0(1'b1, 4'd0, 32'h8000_0000, 32'h8000_0000);
    @(posedge clk); #1;
    chk("flag2_eq", resp0_eq, 1'b1);
    chk("flag2_lt", resp0_lt, 1'b0);
    chk("flag2_ltu", resp0_ltu, 1'b0);

    // A few more functions, including an unknown code
    @(negedge clk);
    set_req0(1'b1, 4'd1, 32'd10, 32'd3);
    @(posedge clk); #1;
    chk("sub_out", resp0_out, 32'd7);
    @(negedge clk);
    set_req0(1'b1, 4'd10, 32'h8000_0000, 32'd4);
    @(posedge clk); #1;
    chk("sra_out", resp0_out, 32'hF800_0000);
    @(negedge clk);
    set_req0(1'b1, 4'd15, 32'd5, 32'd5);
    @(posedge clk); #1;
    chk("unknown_fn_out", resp0_out, 32'd0);
    chk("unknown_fn_eq", resp0_eq, 1'b1);

`ifdef LAB2_PROC_ALU_ARB_STATS_EN
    // Grant counters saturate at all-ones
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    pulse_reset();
    #1;
    chk("cnt0_reset", grant0_cnt, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_req0(1'b1, 4'd0, 32'd1, 32'd2);
      @(posedge clk); #1;
      if (k == 1) chk("cnt0_after2", grant0_cnt, 2'd2);
    end
    chk("cnt0_sat", grant0_cnt, 2'd3);
    chk("cnt1_zero", grant1_cnt, 2'd0);
`endif

    @(negedge clk);
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
